// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared constants for the serial pattern detectors
package seq_detect_pkg;

   localparam logic [3:0] SEQ_1011    = 4'b1011;
   localparam logic       MODE_NONOVL = 1'b0;
   localparam logic       MODE_OVL    = 1'b1;

endpackage

// File: rtl/seq_detect_prog_if.sv
// rtl/seq_detect_prog_if.sv - serial stream, control and status bundle of seq_detect_prog
interface seq_detect_prog_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             inp_bit;
   logic             overlap;
   logic             pat_load;
   logic [PAT_W-1:0] pattern;
   logic             cnt_clr;
   logic             seq_seen;
   logic [CNT_W-1:0] match_count;
   logic             cnt_sat;

   modport master (
      output in_valid, inp_bit, overlap, pat_load, pattern, cnt_clr,
      input  seq_seen, match_count, cnt_sat
   );

   modport slave (
      input  in_valid, inp_bit, overlap, pat_load, pattern, cnt_clr,
      output seq_seen, match_count, cnt_sat
   );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with sticky saturation flag, clear wins
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         sat
);
   localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (inc && count != ALL_ONES) begin
         count <= count + 1'b1;
         // flag rises on the same edge that lands on all-ones
         if (count == ALL_ONES - 1'b1)
            sat <= 1'b1;
      end
   end
endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector with overlap select and match counter
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter int                PAT_W     = 4,
   parameter int                CNT_W     = 8,
   parameter logic [PAT_W-1:0]  RESET_PAT = PAT_W'(SEQ_1011)
) (
   input logic               clk,
   input logic               reset,
   seq_detect_prog_if.slave  bus
);
   localparam int                FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  pat_reg;
   logic [PAT_W-1:0]  history;
   logic [FILL_W-1:0] fill;
   logic              seq_seen_q;
   logic              accept;
   logic              match;
   logic [PAT_W-1:0]  window;
   logic [CNT_W-1:0]  count;
   logic              sat;

   always_comb begin
      accept = bus.in_valid && !bus.pat_load;
      window = {history[PAT_W-2:0], bus.inp_bit};
      match  = accept && (fill == FILL_MAX) && (window == pat_reg);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_reg    <= RESET_PAT;
         history    <= '0;
         fill       <= '0;
         seq_seen_q <= 1'b0;
      end else if (bus.pat_load) begin
         pat_reg    <= bus.pattern;
         history    <= '0;
         fill       <= '0;
         seq_seen_q <= 1'b0;
      end else begin
         seq_seen_q <= match;
         if (accept) begin
            history <= window;
            // non-overlapping mode demands a full fresh window after each hit
            if (match && bus.overlap == MODE_NONOVL)
               fill <= '0;
            else if (fill != FILL_MAX)
               fill <= fill + 1'b1;
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (match),
      .clr   (bus.cnt_clr),
      .count (count),
      .sat   (sat)
   );

   assign bus.seq_seen    = seq_seen_q;
   assign bus.match_count = count;
   assign bus.cnt_sat     = sat;
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - directed self-checking bench for seq_detect_prog
module tb_seq_detect_prog;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_detect_prog_if #(.PAT_W(4), .CNT_W(8)) bus  ();
   seq_detect_prog_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

   seq_detect_prog #(.PAT_W(4), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   seq_detect_prog #(.PAT_W(4), .CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // apply one cycle of inputs to the wide DUT; returns 1 ns after the edge
   task automatic drive(input logic v, input logic b, input logic pl,
                        input logic [3:0] pat, input logic clr);
      @(negedge clk);
      bus.in_valid = v;
      bus.inp_bit  = b;
      bus.pat_load = pl;
      bus.pattern  = pat;
      bus.cnt_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic drive2(input logic v, input logic b, input logic pl,
                         input logic [3:0] pat, input logic clr);
      @(negedge clk);
      bus2.in_valid = v;
      bus2.inp_bit  = b;
      bus2.pat_load = pl;
      bus2.pattern  = pat;
      bus2.cnt_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] stream7;
      logic [6:0] exp_ovl;
      logic [6:0] exp_non;
      logic [3:0] s4;
      logic [9:0] exp2_seq;
      logic [9:0] exp2_sat;
      logic [1:0] exp2_cnt [10];

      stream7  = 7'b1011011;
      exp_ovl  = 7'b0001001;
      exp_non  = 7'b0001000;
      s4       = 4'b1011;
      exp2_seq = 10'b0001111111;
      exp2_sat = 10'b0000011100;
      exp2_cnt = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1};

      bus.in_valid  = 0; bus.inp_bit  = 0; bus.overlap  = 0;
      bus.pat_load  = 0; bus.pattern  = '0; bus.cnt_clr = 0;
      bus2.in_valid = 0; bus2.inp_bit = 0; bus2.overlap = 0;
      bus2.pat_load = 0; bus2.pattern = '0; bus2.cnt_clr = 0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_seq_seen", 32'(bus.seq_seen), 32'd0);
      check("rst_count", 32'(bus.match_count), 32'd0);
      check("rst_sat", 32'(bus.cnt_sat), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // 1: default pattern, single match
      bus.overlap = 0;
      for (int i = 3; i >= 0; i--) begin
         drive(1, s4[i], 0, 4'h0, 0);
         check($sformatf("t1_seq_b%0d", 4 - i), 32'(bus.seq_seen), (i == 0) ? 32'd1 : 32'd0);
      end
      check("t1_count", 32'(bus.match_count), 32'd1);
      drive(0, 0, 0, 4'h0, 0);
      check("t1_pulse_one_cycle", 32'(bus.seq_seen), 32'd0);

      // 2: overlapping then non-overlapping on 1011011
      bus.overlap = 1;
      for (int i = 6; i >= 0; i--) begin
         drive(1, stream7[i], 0, 4'h0, 0);
         check($sformatf("t2_ovl_b%0d", 7 - i), 32'(bus.seq_seen), 32'(exp_ovl[i]));
      end
      check("t2_ovl_count", 32'(bus.match_count), 32'd3);
      bus.overlap = 0;
      drive(0, 0, 1, 4'b1011, 0);
      check("t2_reload_seq", 32'(bus.seq_seen), 32'd0);
      check("t2_reload_count", 32'(bus.match_count), 32'd3);
      for (int i = 6; i >= 0; i--) begin
         drive(1, stream7[i], 0, 4'h0, 0);
         check($sformatf("t2_non_b%0d", 7 - i), 32'(bus.seq_seen), 32'(exp_non[i]));
      end
      check("t2_non_count", 32'(bus.match_count), 32'd4);

      // 3: valid gaps do not break a partial match
      drive(0, 0, 1, 4'b1011, 0);
      for (int i = 3; i >= 0; i--) begin
         drive(1, s4[i], 0, 4'h0, 0);
         check($sformatf("t3_seq_b%0d", 4 - i), 32'(bus.seq_seen), (i == 0) ? 32'd1 : 32'd0);
         if (i != 0) begin
            for (int g = 0; g < 3; g++) begin
               drive(0, 1, 0, 4'h0, 0);
               check($sformatf("t3_gap_b%0d_g%0d", 4 - i, g), 32'(bus.seq_seen), 32'd0);
            end
         end
      end
      check("t3_count", 32'(bus.match_count), 32'd5);
      drive(0, 0, 0, 4'h0, 0);
      check("t3_after", 32'(bus.seq_seen), 32'd0);

      // 4: load 1111 with a concurrent valid bit, which must be dropped
      bus.overlap = 1;
      drive(1, 1, 1, 4'b1111, 0);
      check("t4_load_seq", 32'(bus.seq_seen), 32'd0);
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 0, 4'h0, 0);
         check($sformatf("t4_seq_b%0d", i + 1), 32'(bus.seq_seen), (i >= 3) ? 32'd1 : 32'd0);
      end
      check("t4_count", 32'(bus.match_count), 32'd8);

      // 5: 2-bit counter saturation and clear-vs-match collision
      bus2.overlap = 1;
      drive2(0, 0, 1, 4'b1111, 0);
      for (int i = 0; i < 10; i++) begin
         drive2(1, 1, 0, 4'h0, (i == 8));
         check($sformatf("t5_seq_b%0d", i + 1), 32'(bus2.seq_seen), 32'(exp2_seq[9 - i]));
         check($sformatf("t5_cnt_b%0d", i + 1), 32'(bus2.match_count), 32'(exp2_cnt[i]));
         check($sformatf("t5_sat_b%0d", i + 1), 32'(bus2.cnt_sat), 32'(exp2_sat[9 - i]));
      end
      drive2(0, 0, 0, 4'h0, 0);

      // 6: asynchronous reset mid-stream
      bus.overlap = 0;
      drive(0, 0, 1, 4'b1011, 0);
      drive(1, 1, 0, 4'h0, 0);
      drive(1, 0, 0, 4'h0, 0);
      drive(1, 1, 0, 4'h0, 0);
      #2 reset = 1'b1;
      #1;
      check("t6_async_seq", 32'(bus.seq_seen), 32'd0);
      check("t6_async_count", 32'(bus.match_count), 32'd0);
      check("t6_async_sat", 32'(bus2.cnt_sat), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1, 1, 0, 4'h0, 0);
      check("t6_lone_bit", 32'(bus.seq_seen), 32'd0);
      for (int i = 3; i >= 0; i--) begin
         drive(1, s4[i], 0, 4'h0, 0);
         check($sformatf("t6_seq_b%0d", 4 - i), 32'(bus.seq_seen), (i == 0) ? 32'd1 : 32'd0);
      end
      check("t6_count", 32'(bus.match_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Programmable serial pattern detector. It generalises the fixed 1011 detector to a runtime-loadable PAT_W-bit pattern, with selectable overlapping or non-overlapping matching, input qualification and a saturating match counter. It sits on a serial bit stream beside the other level-1 detectors and feeds a one-cycle seq_seen pulse plus statistics to downstream control.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 8, match counter width (>=1)
RESET_PAT, 4'b1011, pattern register value after reset (width PAT_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  inp_bit is consumed at this clock edge
inp_bit  input  1  serial data bit
overlap  input  1  1 = overlapping matches, 0 = non-overlapping
pat_load  input  1  load pattern into pattern register, restart search
pattern  input  PAT_W  new pattern; MSB is the first bit received
cnt_clr  input  1  synchronous clear of match_count and cnt_sat
seq_seen  output  1  one-cycle match pulse
match_count  output  CNT_W  number of matches since reset or clear
cnt_sat  output  1  sticky: match_count has reached all-ones

Behaviour:
- Reset (async, active-high):
  - pat_reg=RESET_PAT; history=0; fill=0.
  - seq_seen=0, match_count=0, cnt_sat=0.
  - All reset values apply immediately on assertion, even mid-stream.
- State:
  - history[PAT_W-1:0] shift register; newest bit is in the LSB.
  - fill counter runs 0..PAT_W-1 and saturates. It counts bits accepted since the last restart.
- Accepted bit: an edge with in_valid=1 and pat_load=0.
  - history <= {history[PAT_W-2:0], inp_bit}.
  - fill increments, saturating.
- Match condition, evaluated on an accepted bit: fill==PAT_W-1 and {history[PAT_W-2:0], inp_bit}==pat_reg.
- On match:
  - seq_seen=1 for exactly the cycle after that edge.
  - seq_seen is registered, with latency 1 cycle from the completing bit, matching the legacy detector.
  - seq_seen=0 in every other cycle, including cycles with in_valid=0.
  - overlap=1: fill holds at PAT_W-1, so a suffix can start the next match.
  - overlap=0: fill <= 0, so the next match needs PAT_W fresh bits.
  - overlap is sampled at the matching edge only.
- in_valid=0: history, fill and pat_reg hold; seq_seen=0 next cycle. Gaps of any length do not break a partial match.
- pat_load=1:
  - pat_reg <= pattern; history <= 0; fill <= 0; seq_seen <= 0.
  - The concurrent inp_bit is discarded even if in_valid=1.
  - match_count is not affected.
- Counter:
  - A match increments match_count, saturating at 2^CNT_W-1.
  - cnt_sat is set in the same edge that reaches all-ones. It stays set until cnt_clr or reset.
- cnt_clr:
  - match_count <= 0 and cnt_sat <= 0.
  - If a match occurs at the same edge, the clear wins: count=0. seq_seen still pulses.
- Priority: reset > pat_load > accepted bit. cnt_clr is independent of pat_load.
- pattern is don't-care when pat_load=0.

Decomposition:
- Shared package seq_detect_pkg holds the default pattern constant SEQ_1011 = 4'b1011 (used for RESET_PAT) and the overlap-mode encodings MODE_NONOVL=0 and MODE_OVL=1.
- One natural sub-module: sat_counter (parameter W; inputs inc, clr with clr priority; outputs count and sticky sat). It is reusable by the other detectors.
- Window shift/compare and fill logic stay in the top module.

Test Plan:
1. Default pattern, overlap=0, stream 1,0,1,1 with in_valid=1 -> seq_seen=1 exactly one cycle after the 4th bit; match_count=1.
2. Stream 1,0,1,1,0,1,1 -> overlap=1 gives two pulses (after bits 4 and 7), count=2; overlap=0 gives one pulse, count=1.
3. Stream 1,0,1,1 with in_valid low for 3 cycles between every bit -> exactly one pulse after the final accepted bit; no pulse during gaps.
4. pat_load with pattern=4'b1111, in_valid=1, inp_bit=1 in the same cycle -> that bit is dropped. Then six 1s with overlap=1 -> pulses after bits 4, 5 and 6, count increases by 3. The prior count is retained.
5. CNT_W=2, overlap=1, pattern 1111, ten 1s -> count 1,2,3,3...; cnt_sat=1 from the third match on. cnt_clr at the same edge as a match -> count=0, cnt_sat=0, seq_seen still pulses.
6. Assert reset asynchronously (between edges) after bits 1,0,1 -> outputs 0 immediately. After release, bit 1 alone gives no pulse; a full 1,0,1,1 gives one pulse.
